uart_cmd_framer: RTL



---
 rtl/uart_pkg.sv | 15 +
 rtl/cmd_payload_buf.sv | 32 +++
 rtl/uart_cmd_framer.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared types for the UART receive-side command path.
package uart_pkg;

    typedef enum logic [2:0] {
        S_SYNC,
        S_OPC,
        S_LEN,
        S_PAY,
        S_CSUM,
        S_HOLD
    } cmd_state_t;

    localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

endpackage

// File: rtl/cmd_payload_buf.sv
// Payload store for one command: single write port, registered read port.
// The array itself has no reset; only the read register clears.
module cmd_payload_buf #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [7:0]    wdata,
    input  logic [AW-1:0] raddr,
    output logic [7:0]    rd_data
);

    logic [7:0] mem [DEPTH];

    always_ff @(posedge clock) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rd_data <= 8'h00;
        end else begin
            rd_data <= mem[raddr];
        end
    end

endmodule

// File: rtl/uart_cmd_framer.sv
// Frames the UART byte stream into sync/opcode/length/payload/checksum
// commands and holds each validated command for the downstream decoder.
//
//   state  | meaning
//   S_SYNC | hunting for the sync byte, other bytes ignored
//   S_OPC  | next byte is the opcode
//   S_LEN  | next byte is the payload length
//   S_PAY  | collecting payload bytes into the buffer
//   S_CSUM | next byte is the XOR checksum
//   S_HOLD | command valid, waiting for the consumer
module uart_cmd_framer
    import uart_pkg::*;
#(
    parameter int         MAX_LEN      = 16,
    parameter logic [7:0] SYNC_BYTE    = SYNC_BYTE_DEFAULT,
    parameter int         TIMEOUT_CLKS = 4096,
    parameter int         LW           = $clog2(MAX_LEN + 1),
    parameter int         AW           = $clog2(MAX_LEN)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic [7:0]    rx_data,
    input  logic          rx_finish,
    output logic          cmd_valid,
    input  logic          cmd_ready,
    output logic [7:0]    cmd_opcode,
    output logic [LW-1:0] cmd_len,
    input  logic [AW-1:0] rd_addr,
    output logic [7:0]    rd_data,
    output logic          err_csum,
    output logic          err_len,
    output logic          err_timeout,
    output logic          err_overrun
);

    localparam int TW = $clog2(TIMEOUT_CLKS + 1);

    cmd_state_t    state;
    logic [7:0]    csum;
    logic [7:0]    opc_q;
    logic [LW-1:0] len_q;
    logic [AW-1:0] pay_idx;
    logic [TW-1:0] to_cnt;

    logic in_frame;
    logic timed_out;
    logic last_pay;
    logic buf_we;

    assign in_frame  = (state == S_OPC) || (state == S_LEN) ||
                       (state == S_PAY) || (state == S_CSUM);
    // A byte arriving on the terminal-count cycle still counts as in time.
    assign timed_out = in_frame && !rx_finish && (to_cnt == TW'(TIMEOUT_CLKS - 1));
    assign last_pay  = (LW'(pay_idx) + LW'(1)) == len_q;
    assign buf_we    = (state == S_PAY) && rx_finish;

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= S_SYNC;
            csum        <= 8'h00;
            opc_q       <= 8'h00;
            len_q       <= '0;
            pay_idx     <= '0;
            to_cnt      <= '0;
            cmd_valid   <= 1'b0;
            cmd_opcode  <= 8'h00;
            cmd_len     <= '0;
            err_csum    <= 1'b0;
            err_len     <= 1'b0;
            err_timeout <= 1'b0;
            err_overrun <= 1'b0;
        end else begin
            err_csum    <= 1'b0;
            err_len     <= 1'b0;
            err_timeout <= 1'b0;
            err_overrun <= 1'b0;

            if (rx_finish || !in_frame) begin
                to_cnt <= '0;
            end else if (!timed_out) begin
                to_cnt <= to_cnt + TW'(1);
            end

            if (timed_out) begin
                err_timeout <= 1'b1;
                state       <= S_SYNC;
            end else begin
                case (state)
                    S_SYNC: begin
                        if (rx_finish && (rx_data == SYNC_BYTE)) begin
                            state <= S_OPC;
                        end
                    end
                    S_OPC: begin
                        if (rx_finish) begin
                            opc_q <= rx_data;
                            csum  <= rx_data;
                            state <= S_LEN;
                        end
                    end
                    S_LEN: begin
                        if (rx_finish) begin
                            if (rx_data > 8'(MAX_LEN)) begin
                                err_len <= 1'b1;
                                state   <= S_SYNC;
                            end else begin
                                len_q   <= LW'(rx_data);
                                csum    <= csum ^ rx_data;
                                pay_idx <= '0;
                                state   <= (rx_data == 8'h00) ? S_CSUM : S_PAY;
                            end
                        end
                    end
                    S_PAY: begin
                        if (rx_finish) begin
                            csum    <= csum ^ rx_data;
                            pay_idx <= pay_idx + AW'(1);
                            if (last_pay) begin
                                state <= S_CSUM;
                            end
                        end
                    end
                    S_CSUM: begin
                        if (rx_finish) begin
                            if (rx_data == csum) begin
                                cmd_valid  <= 1'b1;
                                cmd_opcode <= opc_q;
                                cmd_len    <= len_q;
                                state      <= S_HOLD;
                            end else begin
                                err_csum <= 1'b1;
                                state    <= S_SYNC;
                            end
                        end
                    end
                    S_HOLD: begin
                        // Bytes here are dropped, never reinterpreted as sync.
                        if (rx_finish) begin
                            err_overrun <= 1'b1;
                        end
                        if (cmd_valid && cmd_ready) begin
                            cmd_valid <= 1'b0;
                            state     <= S_SYNC;
                        end
                    end
                    default: state <= S_SYNC;
                endcase
            end
        end
    end

    cmd_payload_buf #(
        .DEPTH (MAX_LEN),
        .AW    (AW)
    ) u_buf (
        .clock   (clock),
        .reset   (reset),
        .we      (buf_we),
        .waddr   (pay_idx),
        .wdata   (rx_data),
        .raddr   (rd_addr),
        .rd_data (rd_data)
    );

endmodule
